center_collect: RTL and testbench

- Downstream neighbour of the stage-2 cosine/center pipeline.
- During assignment stage 6 it accepts per-lane results: operand1 carries the center id, operand2 carries dnorm.
- It drops sentinel (unassigned) lanes and packs the surviving {id, dnorm} records, in lane order, into a small FWFT FIFO.
- It drains the FIFO through a valid/ready port to the result writer, back-pressures the stage-2 pipeline via stall, and flags completion once the pipeline has finished and the FIFO has drained.

---
 rtl/center_collect_pkg.sv | 25 ++
 rtl/center_collect_if.sv | 12 +
 rtl/center_collect_multi_write_fifo.sv | 53 +++++
 rtl/center_collect.sv | 103 ++++++++++
 tb/tb_center_collect.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/center_collect_pkg.sv
// Shared constants, stage encoding and record type for the center collector.
package center_collect_pkg;

  localparam int N             = 4096;
  localparam int PARA          = 8;
  localparam int WIDTH         = 16;
  localparam int PARALLEL_SIZE = 2;
  localparam int DEPTH         = 8;
  localparam int CNT_W         = 16;

  localparam logic [WIDTH-1:0] SENTINEL_ID    = 16'd4096;
  localparam logic [2:0]       ASSIGN_STAGE   = 3'd6;
  localparam logic [2:0]       FINISHED_STAGE = 3'd7;

  typedef struct packed {
    logic [WIDTH-1:0] id;
    logic [WIDTH-1:0] dnorm;
  } center_rec_t;

  // A lane carries a real result unless its id is the "no center" sentinel.
  function automatic logic is_live(input logic [WIDTH-1:0] id);
    return (id != SENTINEL_ID);
  endfunction

endpackage

// File: rtl/center_collect_if.sv
// Result drain port: valid/ready handshake carrying one {id, dnorm} record.
interface center_collect_if;
  import center_collect_pkg::*;

  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_id_o;
  logic [WIDTH-1:0] out_dnorm_o;

  modport master (output out_valid_o, output out_id_o, output out_dnorm_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_id_o, input out_dnorm_o, output out_ready_i);
endinterface

// File: rtl/center_collect_multi_write_fifo.sv
// First-word-fall-through FIFO taking up to LANES pre-compacted records per
// cycle at consecutive tail slots and releasing one record per cycle.
module multi_write_fifo
  import center_collect_pkg::*;
#(
  parameter int FIFO_DEPTH = DEPTH,
  parameter int LANES      = PARALLEL_SIZE,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1,
  localparam int NW_W      = $clog2(LANES + 1)
) (
  input  logic                    CLK_i,
  input  logic                    RST_ni,
  input  logic [NW_W-1:0]         wr_num,
  input  center_rec_t [LANES-1:0] wr_data,
  input  logic                    rd_en,
  output center_rec_t             head,
  output logic [CW-1:0]           count
);

  center_rec_t          mem_r [FIFO_DEPTH];
  logic        [AW-1:0] wr_ptr_r;
  logic        [AW-1:0] rd_ptr_r;
  logic        [CW-1:0] count_r;

  // Storage: write the first wr_num compacted records from the tail onward.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (NW_W'(i) < wr_num) mem_r[wr_ptr_r + AW'(i)] <= wr_data[i];
      end
    end
  end

  // Pointers wrap naturally; occupancy tracks writes minus the pop.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(wr_num);
      rd_ptr_r <= rd_ptr_r + AW'(rd_en);
      count_r  <= count_r + CW'(wr_num) - CW'(rd_en);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/center_collect.sv
// Collects assigned-center results from stage 2, drops sentinel lanes,
// buffers survivors in lane order and drains them to the result writer.
module center_collect
  import center_collect_pkg::*;
(
  input  logic                           CLK_i,
  input  logic                           RST_ni,
  input  logic [2:0]                     stage_i,
  input  logic                           finished_i,
  input  logic [PARALLEL_SIZE*WIDTH-1:0] center_id_i,
  input  logic [PARALLEL_SIZE*WIDTH-1:0] dnorm_i,
  output logic                           stall_o,
  center_collect_if.master               out_if,
  output logic [CNT_W-1:0]               rec_count_o,
  output logic                           done_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NW_W = $clog2(PARALLEL_SIZE + 1);
  localparam int LW   = (PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1;
  localparam int RW   = CNT_W + 1;

  logic                            cap_s;
  logic                            stall_s;
  logic                            valid_s;
  logic                            rd_s;
  logic [NW_W-1:0]                 nw_s;
  center_rec_t [PARALLEL_SIZE-1:0] wr_data_s;
  center_rec_t                     head_s;
  logic [CW-1:0]                   count_s;
  logic [RW-1:0]                   rec_sum_s;
  logic [CNT_W-1:0]                rec_r;
  logic                            fin_r;
  logic                            done_r;

  // Stall looks only at registered occupancy so it never depends on ready.
  assign stall_s = (CW'(DEPTH) - count_s) < CW'(PARALLEL_SIZE);
  assign cap_s   = (stage_i == ASSIGN_STAGE) && !stall_s;
  assign valid_s = (count_s != '0);
  assign rd_s    = valid_s && out_if.out_ready_i;

  // Lane filter and compaction: live lanes packed into slots 0.. in lane order.
  always_comb begin
    int slot;
    wr_data_s = '0;
    slot      = 0;
    for (int k = 0; k < PARALLEL_SIZE; k++) begin
      if (cap_s && is_live(center_id_i[k*WIDTH +: WIDTH])) begin
        wr_data_s[slot[LW-1:0]] = {center_id_i[k*WIDTH +: WIDTH], dnorm_i[k*WIDTH +: WIDTH]};
        slot = slot + 1;
      end else begin
        slot = slot;
      end
    end
    nw_s = NW_W'(slot);
  end

  multi_write_fifo #(
    .FIFO_DEPTH (DEPTH),
    .LANES      (PARALLEL_SIZE)
  ) u_fifo (
    .CLK_i   (CLK_i),
    .RST_ni  (RST_ni),
    .wr_num  (nw_s),
    .wr_data (wr_data_s),
    .rd_en   (rd_s),
    .head    (head_s),
    .count   (count_s)
  );

  assign rec_sum_s = {1'b0, rec_r} + RW'(nw_s);

  // Accepted-record counter, saturating at all-ones.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      rec_r <= '0;
    end else if (rec_sum_s[CNT_W]) begin
      rec_r <= '1;
    end else begin
      rec_r <= rec_sum_s[CNT_W-1:0];
    end
  end

  // Finished latch and sticky done once the pipeline is over and we are empty.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      fin_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      fin_r  <= fin_r | finished_i;
      done_r <= done_r | ((fin_r | finished_i) && (count_s == '0) && (nw_s == '0));
    end
  end

  assign stall_o            = stall_s;
  assign out_if.out_valid_o = valid_s;
  assign out_if.out_id_o    = head_s.id;
  assign out_if.out_dnorm_o = head_s.dnorm;
  assign rec_count_o        = rec_r;
  assign done_o             = done_r;

endmodule

// File: tb/tb_center_collect.sv
// Directed table-driven bench for center_collect plus hand-written reset cases.
module tb_center_collect;
  import center_collect_pkg::*;

  localparam logic [15:0] NS = 16'd4096;

  typedef struct {
    logic [2:0]  stage;
    logic        fin;
    logic [15:0] id0, id1, dn0, dn1;
    logic        rdy;
    logic        ev;
    logic [15:0] eid, edn;
    logic        estall;
    logic [15:0] erec;
    logic        edone;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  stage;
  logic        fin;
  logic [31:0] ids;
  logic [31:0] dns;
  logic        stall;
  logic [15:0] rec;
  logic        done;
  int          n_vec;
  int          n_fail;
  vec_t        tbl [32];

  center_collect_if out_if ();

  center_collect dut (
    .CLK_i       (clk),
    .RST_ni      (rst_n),
    .stage_i     (stage),
    .finished_i  (fin),
    .center_id_i (ids),
    .dnorm_i     (dns),
    .stall_o     (stall),
    .out_if      (out_if),
    .rec_count_o (rec),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] st, input logic f, input logic [15:0] i0, input logic [15:0] i1,
                              input logic [15:0] d0, input logic [15:0] d1, input logic r, input logic ev,
                              input logic [15:0] eid, input logic [15:0] edn, input logic es,
                              input logic [15:0] er, input logic ed);
    vec_t v;
    v.stage = st; v.fin = f; v.id0 = i0; v.id1 = i1; v.dn0 = d0; v.dn1 = d1; v.rdy = r;
    v.ev = ev; v.eid = eid; v.edn = edn; v.estall = es; v.erec = er; v.edone = ed;
    return v;
  endfunction

  task automatic drive(input logic [2:0] st, input logic f, input logic [15:0] i0, input logic [15:0] i1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic r);
    stage = st;
    fin = f;
    ids = {i1, i0};
    dns = {d1, d0};
    out_if.out_ready_i = r;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    //              stg  fin id0    id1    dn0        dn1        rdy  ev  eid    edn        st  rec     dn
    tbl[0]  = mk(3'd0, 0, 16'd5,  NS,    16'h0,     16'h0,     1, 0, 16'd0,  16'h0,     0, 16'd0,  0);
    tbl[1]  = mk(3'd7, 0, 16'd5,  16'd6, 16'h0,     16'h0,     1, 0, 16'd0,  16'h0,     0, 16'd0,  0);
    tbl[2]  = mk(3'd6, 0, 16'd5,  NS,    16'h3C00,  16'h4000,  1, 0, 16'd0,  16'h0,     0, 16'd0,  0);
    tbl[3]  = mk(3'd6, 0, NS,     16'd9, 16'h3C00,  16'h4000,  1, 1, 16'd5,  16'h3C00,  0, 16'd1,  0);
    tbl[4]  = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd9,  16'h4000,  0, 16'd2,  0);
    tbl[5]  = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     0, 0, 16'd0,  16'h0,     0, 16'd2,  0);
    tbl[6]  = mk(3'd6, 0, 16'd10, 16'd11, 16'h100A, 16'h100B,  0, 0, 16'd0,  16'h0,     0, 16'd2,  0);
    tbl[7]  = mk(3'd6, 0, 16'd12, 16'd13, 16'h100C, 16'h100D,  0, 1, 16'd10, 16'h100A,  0, 16'd4,  0);
    tbl[8]  = mk(3'd6, 0, 16'd14, 16'd15, 16'h100E, 16'h100F,  0, 1, 16'd10, 16'h100A,  0, 16'd6,  0);
    tbl[9]  = mk(3'd6, 0, 16'd16, 16'd17, 16'h1010, 16'h1011,  0, 1, 16'd10, 16'h100A,  0, 16'd8,  0);
    tbl[10] = mk(3'd6, 0, 16'd18, 16'd19, 16'h1012, 16'h1013,  0, 1, 16'd10, 16'h100A,  1, 16'd10, 0);
    tbl[11] = mk(3'd6, 0, 16'd18, 16'd19, 16'h1012, 16'h1013,  1, 1, 16'd10, 16'h100A,  1, 16'd10, 0);
    tbl[12] = mk(3'd6, 0, 16'd18, 16'd19, 16'h1012, 16'h1013,  1, 1, 16'd11, 16'h100B,  1, 16'd10, 0);
    tbl[13] = mk(3'd6, 0, 16'd18, 16'd19, 16'h1012, 16'h1013,  1, 1, 16'd12, 16'h100C,  0, 16'd10, 0);
    tbl[14] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd13, 16'h100D,  1, 16'd12, 0);
    tbl[15] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd14, 16'h100E,  0, 16'd12, 0);
    tbl[16] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd15, 16'h100F,  0, 16'd12, 0);
    tbl[17] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd16, 16'h1010,  0, 16'd12, 0);
    tbl[18] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd17, 16'h1011,  0, 16'd12, 0);
    tbl[19] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd18, 16'h1012,  0, 16'd12, 0);
    tbl[20] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd19, 16'h1013,  0, 16'd12, 0);
    tbl[21] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 0, 16'd0,  16'h0,     0, 16'd12, 0);
    tbl[22] = mk(3'd6, 0, 16'd20, 16'd21, 16'h1014, 16'h1015,  0, 0, 16'd0,  16'h0,     0, 16'd12, 0);
    tbl[23] = mk(3'd6, 0, 16'd22, NS,    16'h1016,  16'h0,     0, 1, 16'd20, 16'h1014,  0, 16'd14, 0);
    tbl[24] = mk(3'd7, 1, 16'd0,  16'd0, 16'h0,     16'h0,     0, 1, 16'd20, 16'h1014,  0, 16'd15, 0);
    tbl[25] = mk(3'd7, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd20, 16'h1014,  0, 16'd15, 0);
    tbl[26] = mk(3'd7, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd21, 16'h1015,  0, 16'd15, 0);
    tbl[27] = mk(3'd7, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 1, 16'd22, 16'h1016,  0, 16'd15, 0);
    tbl[28] = mk(3'd7, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 0, 16'd0,  16'h0,     0, 16'd15, 0);
    tbl[29] = mk(3'd7, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 0, 16'd0,  16'h0,     0, 16'd15, 1);
    tbl[30] = mk(3'd6, 0, NS,     NS,    16'h1234,  16'h5678,  1, 0, 16'd0,  16'h0,     0, 16'd15, 1);
    tbl[31] = mk(3'd0, 0, 16'd0,  16'd0, 16'h0,     16'h0,     1, 0, 16'd0,  16'h0,     0, 16'd15, 1);

    rst_n = 1'b0;
    drive(3'd0, 1'b0, 16'd0, 16'd0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: check state seen during cycle i, then apply that cycle's inputs.
    for (int i = 0; i < 32; i++) begin
      logic ok;
      @(negedge clk);
      ok = (out_if.out_valid_o === tbl[i].ev) && (stall === tbl[i].estall) &&
           (rec === tbl[i].erec) && (done === tbl[i].edone) &&
           (!tbl[i].ev || ((out_if.out_id_o === tbl[i].eid) && (out_if.out_dnorm_o === tbl[i].edn)));
      n_vec++;
      if (!ok) begin
        n_fail++;
        $display("FAIL vec%0d: got valid=%0b id=%0d dnorm=%h stall=%0b rec=%0d done=%0b, expected valid=%0b id=%0d dnorm=%h stall=%0b rec=%0d done=%0b",
                 i, out_if.out_valid_o, out_if.out_id_o, out_if.out_dnorm_o, stall, rec, done,
                 tbl[i].ev, tbl[i].eid, tbl[i].edn, tbl[i].estall, tbl[i].erec, tbl[i].edone);
      end
      drive(tbl[i].stage, tbl[i].fin, tbl[i].id0, tbl[i].id1, tbl[i].dn0, tbl[i].dn1, tbl[i].rdy);
    end

    // Mid-stream asynchronous reset with five records buffered.
    @(negedge clk);
    drive(3'd6, 1'b0, 16'd30, 16'd31, 16'h2000, 16'h2001, 1'b0);
    @(negedge clk);
    drive(3'd6, 1'b0, 16'd32, 16'd33, 16'h2002, 16'h2003, 1'b0);
    @(negedge clk);
    drive(3'd6, 1'b0, 16'd34, NS, 16'h2004, 16'h0, 1'b0);
    @(negedge clk);
    drive(3'd0, 1'b0, 16'd0, 16'd0, 16'h0, 16'h0, 1'b0);
    chk("pre_reset_rec", {16'd0, rec}, 32'd20);
    chk("pre_reset_head", {16'd0, out_if.out_id_o}, 32'd30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_if.out_valid_o}, 32'd0);
    chk("arst_rec", {16'd0, rec}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd6, 1'b0, 16'd40, NS, 16'h5555, 16'h0, 1'b0);
    @(negedge clk);
    drive(3'd0, 1'b0, 16'd0, 16'd0, 16'h0, 16'h0, 1'b1);
    chk("post_reset_head_id", {15'd0, out_if.out_valid_o, out_if.out_id_o}, {15'd0, 1'b1, 16'd40});
    chk("post_reset_head_dnorm", {16'd0, out_if.out_dnorm_o}, 32'h5555);
    chk("post_reset_rec", {16'd0, rec}, 32'd1);
    @(negedge clk);
    chk("post_reset_drained", {31'd0, out_if.out_valid_o}, 32'd0);
    @(negedge clk);
    chk("post_reset_fin_cleared", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
